// File: rtl/v_latch_bank.sv
// Clocked multi-channel value hold bank with per-channel change flag and saturating change counter.
// Optional feature macro: LATCH_BANK_PARITY_EN (registered even parity of each held value on PAR).
module v_latch_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CW       = 4
) (
  input  logic                      C,
  input  logic                      CLR_N,
  input  logic [CHANNELS-1:0]       G,
  input  logic [CHANNELS-1:0]       SCLR,
  input  logic [CHANNELS*WIDTH-1:0] D,
  input  logic [CHANNELS-1:0]       ACK,
  output logic [CHANNELS*WIDTH-1:0] Q,
  output logic [CHANNELS-1:0]       CHG,
  output logic [CHANNELS*CW-1:0]    CNT,
  output logic [CHANNELS-1:0]       PAR
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CHANNELS*WIDTH-1:0] q_r;
  logic [CHANNELS*WIDTH-1:0] q_nxt_s;
  logic [CHANNELS-1:0]       chg_r;
  logic [CHANNELS-1:0]       chg_nxt_s;
  logic [CHANNELS*CW-1:0]    cnt_r;
  logic [CHANNELS*CW-1:0]    cnt_nxt_s;

  // Per-channel next state: clear beats write, and a fresh change beats an acknowledge.
  always_comb begin
    q_nxt_s   = q_r;
    chg_nxt_s = chg_r;
    cnt_nxt_s = cnt_r;
    for (int i = 0; i < CHANNELS; i++) begin
      if (SCLR[i]) begin
        q_nxt_s[i*WIDTH +: WIDTH] = {WIDTH{1'b0}};
        cnt_nxt_s[i*CW +: CW]     = {CW{1'b0}};
        chg_nxt_s[i]              = 1'b0;
      end else if (G[i] && (D[i*WIDTH +: WIDTH] != q_r[i*WIDTH +: WIDTH])) begin
        q_nxt_s[i*WIDTH +: WIDTH] = D[i*WIDTH +: WIDTH];
        chg_nxt_s[i]              = 1'b1;
        if (cnt_r[i*CW +: CW] != CNT_MAX) begin
          cnt_nxt_s[i*CW +: CW] = cnt_r[i*CW +: CW] + CNT_ONE;
        end else begin
          cnt_nxt_s[i*CW +: CW] = CNT_MAX;
        end
      end else if (ACK[i]) begin
        chg_nxt_s[i] = 1'b0;
      end else begin
        chg_nxt_s[i] = chg_r[i];
      end
    end
  end

  // State registers; reset clears every channel at once.
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      q_r   <= '0;
      chg_r <= '0;
      cnt_r <= '0;
    end else begin
      q_r   <= q_nxt_s;
      chg_r <= chg_nxt_s;
      cnt_r <= cnt_nxt_s;
    end
  end

  assign Q   = q_r;
  assign CHG = chg_r;
  assign CNT = cnt_r;

`ifdef LATCH_BANK_PARITY_EN
  function automatic logic even_par(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic [CHANNELS-1:0] par_r;
  logic [CHANNELS-1:0] par_nxt_s;

  // Parity is taken from the value about to be registered so it lines up with Q.
  always_comb begin
    par_nxt_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      par_nxt_s[i] = even_par(q_nxt_s[i*WIDTH +: WIDTH]);
    end
  end

  // Parity register, same reset as the held values.
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      par_r <= '0;
    end else begin
      par_r <= par_nxt_s;
    end
  end

  assign PAR = par_r;
`else
  assign PAR = {CHANNELS{1'b0}};
`endif

endmodule

// File: tb/tb_v_latch_bank.sv
// Directed self-checking bench for v_latch_bank (default WIDTH=8, CHANNELS=4, CW=4).
module tb_v_latch_bank;

  logic        C;
  logic        CLR_N;
  logic [3:0]  G;
  logic [3:0]  SCLR;
  logic [31:0] D;
  logic [3:0]  ACK;
  logic [31:0] Q;
  logic [3:0]  CHG;
  logic [15:0] CNT;
  logic [3:0]  PAR;

  int checks = 0;
  int errors = 0;

  v_latch_bank #(.WIDTH(8), .CHANNELS(4), .CW(4)) dut (
    .C(C), .CLR_N(CLR_N), .G(G), .SCLR(SCLR), .D(D), .ACK(ACK),
    .Q(Q), .CHG(CHG), .CNT(CNT), .PAR(PAR)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] eq, input logic [3:0] echg,
                           input logic [15:0] ecnt);
    check_val({tag, "_q"}, Q, eq);
    check_val({tag, "_chg"}, {28'h0, CHG}, {28'h0, echg});
    check_val({tag, "_cnt"}, {16'h0, CNT}, {16'h0, ecnt});
  endtask

  logic [3:0] par_exp;

  initial begin
    CLR_N = 1'b0; G = 4'h0; SCLR = 4'h0; D = 32'h0; ACK = 4'h0;
    #1;
    check_all("rst0", 32'h0, 4'h0, 16'h0);

    // 1: activity under reset is ignored
    G = 4'hF; D = 32'hDEADBEEF; ACK = 4'h0;
    for (int k = 0; k < 3; k++) begin
      tick();
      D = D ^ 32'h5A5A5A5A;
      check_all("rst_hold", 32'h0, 4'h0, 16'h0);
      check_val("rst_par", {28'h0, PAR}, 32'h0);
    end
    G = 4'h0;
    CLR_N = 1'b1;
    tick();
    G = 4'b0001; D = 32'h000000A5;
    tick();
    check_all("first_wr", 32'h000000A5, 4'b0001, 16'h0001);

    // 2: same value does not count, ACK clears flag
    tick();
    check_all("same_wr", 32'h000000A5, 4'b0001, 16'h0001);
    G = 4'h0; ACK = 4'b0001;
    tick();
    check_all("ack_clr", 32'h000000A5, 4'b0000, 16'h0001);
    ACK = 4'h0; G = 4'b0001;
    tick();
    check_all("same_noflag", 32'h000000A5, 4'b0000, 16'h0001);

    // 3: change wins over simultaneous ACK
    ACK = 4'b0001; D = 32'h0000003C;
    tick();
    check_all("ack_vs_chg", 32'h0000003C, 4'b0001, 16'h0002);
    ACK = 4'h0;

    // 4: channel 1 counter saturation
    G = 4'b0010;
    for (int k = 0; k < 20; k++) begin
      D = {16'h0, 8'(k + 1), 8'h3C};
      tick();
      check_val("sat_cnt", {28'h0, CNT[7:4]}, (k + 1 > 15) ? 32'd15 : 32'(k + 1));
    end
    check_all("sat_end", 32'h0000143C, 4'b0011, 16'h00F2);
    SCLR = 4'b0010; D = 32'h0000553C;
    tick();
    check_all("sclr", 32'h0000003C, 4'b0001, 16'h0002);
    SCLR = 4'h0;

    // 5: only gated channels update, then asynchronous reset mid-cycle
    G = 4'b1010; D = 32'h11223344;
    tick();
    check_all("gate_mask", 32'h1100333C, 4'b1011, 16'h1012);
    G = 4'h0;
    #2;
    CLR_N = 1'b0;
    #1;
    check_all("async_rst", 32'h0, 4'h0, 16'h0);
    check_val("async_par", {28'h0, PAR}, 32'h0);
    #3;
    CLR_N = 1'b1;
    G = 4'b0001; D = 32'h0;
    tick();
    check_all("post_rst_zero", 32'h0, 4'h0, 16'h0);
    G = 4'h0; ACK = 4'b0001;
    tick();
    check_all("ack_idle", 32'h0, 4'h0, 16'h0);
    ACK = 4'h0;

    // 6: parity
    G = 4'b0001; D = 32'h00000007;
`ifdef LATCH_BANK_PARITY_EN
    par_exp = 4'b0001;
`else
    par_exp = 4'b0000;
`endif
    tick();
    check_val("par_07", {28'h0, PAR}, {28'h0, par_exp});
    D = 32'h00000003;
    tick();
    check_val("par_03", {28'h0, PAR}, 32'h0);
    D = 32'h00000007;
    tick();
    check_val("par_07b", {28'h0, PAR}, {28'h0, par_exp});
    G = 4'h0; SCLR = 4'b0001;
    tick();
    check_val("par_sclr", {28'h0, PAR}, 32'h0);
    check_all("final", 32'h0, 4'h0, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
